// File: rtl/lin_recur_gen_if.sv
// Stream and control bundle for lin_recur_gen: run control, seed/tap setup, term stream and status.
interface lin_recur_gen_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ORDER = 3,
    parameter int unsigned LEN_W = 16
);
    logic                   start;
    logic                   abort;
    logic [ORDER*WIDTH-1:0] seed;
    logic [ORDER-1:0]       tap_mask;
    logic [LEN_W-1:0]       len;
    logic                   stop_on_ovf;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   done;
    logic                   ovf;

    modport master (
        output start, abort, seed, tap_mask, len, stop_on_ovf, out_ready,
        input  out_data, out_valid, busy, done, ovf
    );

    modport slave (
        input  start, abort, seed, tap_mask, len, stop_on_ovf, out_ready,
        output out_data, out_valid, busy, done, ovf
    );
endinterface

// File: rtl/lin_recur_gen.sv
// Linear-recurrence term generator: emits the oldest history term per transfer and appends the
// sum of the tapped history terms, with optional length limit and overflow stop.
module lin_recur_gen #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ORDER = 3,
    parameter int unsigned LEN_W = 16
) (
    input logic            clk,
    input logic            rst,
    lin_recur_gen_if.slave bus
);
    localparam int unsigned SumW = WIDTH + $clog2(ORDER);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hist_q [ORDER];
    logic [WIDTH-1:0] hist_d [ORDER];
    logic [ORDER-1:0] tap_q, tap_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             stop_q, stop_d;
    logic             ovf_q, ovf_d;

    logic [SumW-1:0]  sum;
    logic             sum_ovf;
    logic             xfer;
    logic             len_hit;

    // Full-precision sum so any carry past WIDTH is visible as overflow.
    always_comb begin
        sum = '0;
        for (int k = 0; k < ORDER; k++) begin
            if (tap_q[k]) sum = sum + SumW'(hist_q[k]);
        end
    end

    assign sum_ovf = |sum[SumW-1:WIDTH];
    assign xfer    = (state_q == StRun) && bus.out_ready;
    assign len_hit = (len_q != '0) && (cnt_q == len_q - LEN_W'(1));

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        tap_d   = tap_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        ovf_d   = ovf_q;

        if (bus.abort) begin
            state_d = StIdle;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        for (int k = 0; k < ORDER; k++) begin
                            hist_d[k] = bus.seed[k*WIDTH +: WIDTH];
                        end
                        tap_d   = bus.tap_mask;
                        len_d   = bus.len;
                        stop_d  = bus.stop_on_ovf;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (xfer) begin
                        for (int k = 0; k < ORDER - 1; k++) begin
                            hist_d[k] = hist_q[k+1];
                        end
                        hist_d[ORDER-1] = sum[WIDTH-1:0];
                        cnt_d           = cnt_q + LEN_W'(1);
                        if (sum_ovf) ovf_d = 1'b1;
                        if ((sum_ovf && stop_q) || len_hit) state_d = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            for (int k = 0; k < ORDER; k++) hist_q[k] <= '0;
            tap_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            tap_q   <= tap_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_data  = hist_q[0];
    assign bus.out_valid = (state_q == StRun);
    assign bus.busy      = (state_q == StRun);
    assign bus.done      = (state_q == StDone);
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_lin_recur_gen.sv
// Scoreboard bench for lin_recur_gen: a 32-bit instance for sequence/control scenarios and an
// 8-bit instance for overflow handling.
module tb_lin_recur_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        sel = 1'b0;
    logic        rdy = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] h0 = '0, h1 = '0, h2 = '0;
    logic [2:0]  taps = '0;
    logic [15:0] len = '0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q [$];
    int          oa;

    lin_recur_gen_if #(.WIDTH(32), .ORDER(3), .LEN_W(16)) g ();
    lin_recur_gen_if #(.WIDTH(8),  .ORDER(3), .LEN_W(16)) s ();

    lin_recur_gen #(.WIDTH(32), .ORDER(3), .LEN_W(16)) u_dut_g (.clk(clk), .rst(rst), .bus(g));
    lin_recur_gen #(.WIDTH(8),  .ORDER(3), .LEN_W(16)) u_dut_s (.clk(clk), .rst(rst), .bus(s));

    assign g.start       = start & ~sel;
    assign s.start       = start & sel;
    assign g.abort       = abort;
    assign s.abort       = abort;
    assign g.seed        = {h2, h1, h0};
    assign s.seed        = {h2[7:0], h1[7:0], h0[7:0]};
    assign g.tap_mask    = taps;
    assign s.tap_mask    = taps;
    assign g.len         = len;
    assign s.len         = len;
    assign g.stop_on_ovf = stop;
    assign s.stop_on_ovf = stop;
    assign g.out_ready   = rdy;
    assign s.out_ready   = rdy;

    logic [31:0] cur_data;
    logic        cur_valid, cur_busy, cur_done, cur_ovf;
    assign cur_data  = sel ? {24'h0, s.out_data} : g.out_data;
    assign cur_valid = sel ? s.out_valid : g.out_valid;
    assign cur_busy  = sel ? s.busy : g.busy;
    assign cur_done  = sel ? s.done : g.done;
    assign cur_ovf   = sel ? s.ovf : g.ovf;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pushes n terms and reports the first term index at which ovf should show.
    task automatic push_seq(input int n, input int w, output int ovf_at);
        logic [63:0] m [3];
        logic [63:0] mask, nx;
        mask   = (64'd1 << w) - 64'd1;
        m[0]   = 64'(h0) & mask;
        m[1]   = 64'(h1) & mask;
        m[2]   = 64'(h2) & mask;
        ovf_at = -1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(m[0]);
            nx = '0;
            for (int k = 0; k < 3; k++) if (taps[k]) nx = nx + m[k];
            if (ovf_at < 0 && (nx >> w) != 0) ovf_at = i + 1;
            m[0] = m[1];
            m[1] = m[2];
            m[2] = nx & mask;
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        rdy   = 1'b0;
        tick();
        abort = 1'b0;
    endtask

    // Consume n terms; optionally random backpressure and a start pulse at term pulse_at.
    task automatic stream(input int n, input bit rnd, input int ovf_at, input int pulse_at);
        int got = 0;
        int cyc = 0;
        bit pulsed = 1'b0;
        while (got < n && cyc < 1000) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse_at >= 0 && got == pulse_at && !pulsed) begin
                start  = 1'b1;
                h0     = 32'd99;
                taps   = 3'b111;
                len    = 16'd3;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (cur_valid) begin
                if (exp_q.size() == 0) check_eq("extra_term", cur_data, 64'hdead);
                else check_eq("data", cur_data, exp_q[0]);
                check_eq("ovf_run", cur_ovf, (ovf_at >= 0 && got >= ovf_at));
                if (rdy) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    got++;
                end
            end else begin
                check_eq("valid_run", cur_valid, 1);
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check_eq("term_count", got, n);
    endtask

    task automatic set_padovan();
        h0 = 32'd0; h1 = 32'd1; h2 = 32'd1;
        taps = 3'b011; len = 16'd0; stop = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check_eq("rst_async_valid", g.out_valid, 0);
        #9 rst = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            sel = 1'(i);
            #0;
            check_eq("rst_data", cur_data, 0);
            check_eq("rst_valid", cur_valid, 0);
            check_eq("rst_busy", cur_busy, 0);
            check_eq("rst_done", cur_done, 0);
            check_eq("rst_ovf", cur_ovf, 0);
        end
        sel = 1'b0;

        // Padovan, unlimited length
        set_padovan();
        push_seq(16, 32, oa);
        start_run();
        stream(16, 1'b0, -1, -1);
        do_abort();
        check_eq("abort_valid", cur_valid, 0);
        check_eq("abort_busy", cur_busy, 0);

        // Fibonacci with length limit
        taps = 3'b110; len = 16'd10;
        push_seq(10, 32, oa);
        start_run();
        stream(10, 1'b0, -1, -1);
        check_eq("len_done", cur_done, 1);
        check_eq("len_valid", cur_valid, 0);
        check_eq("len_busy", cur_busy, 0);
        check_eq("len_ovf", cur_ovf, 0);

        // Padovan under backpressure, launched from DONE
        set_padovan();
        push_seq(16, 32, oa);
        start_run();
        stream(16, 1'b1, -1, -1);
        do_abort();
        check_eq("bp_drained", exp_q.size(), 0);

        // 8-bit overflow stop
        sel = 1'b1;
        set_padovan();
        stop = 1'b1;
        push_seq(20, 8, oa);
        start_run();
        stream(20, 1'b0, -1, -1);
        check_eq("ovfstop_done", cur_done, 1);
        check_eq("ovfstop_ovf", cur_ovf, 1);
        check_eq("ovfstop_valid", cur_valid, 0);
        rdy = 1'b1;
        tick();
        check_eq("ovfstop_hold_valid", cur_valid, 0);
        check_eq("ovfstop_hold_ovf", cur_ovf, 1);

        // 8-bit overflow wrap
        stop = 1'b0;
        push_seq(23, 8, oa);
        start_run();
        stream(23, 1'b0, oa, -1);
        check_eq("wrap_valid", cur_valid, 1);
        check_eq("wrap_ovf", cur_ovf, 1);
        do_abort();
        check_eq("wrap_abort_ovf", cur_ovf, 0);
        sel = 1'b0;

        // abort with simultaneous start and transfer
        set_padovan();
        push_seq(5, 32, oa);
        start_run();
        stream(5, 1'b0, -1, -1);
        abort = 1'b1; start = 1'b1; rdy = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check_eq("abst_valid", cur_valid, 0);
        check_eq("abst_busy", cur_busy, 0);
        check_eq("abst_done", cur_done, 0);
        check_eq("abst_ovf", cur_ovf, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("abst_no_restart", cur_valid, 0);
        end
        exp_q.delete();

        // start pulse and setup changes during RUN are ignored
        set_padovan();
        push_seq(12, 32, oa);
        start_run();
        stream(12, 1'b0, -1, 4);
        do_abort();

        // asynchronous reset mid-run
        set_padovan();
        push_seq(4, 32, oa);
        start_run();
        stream(4, 1'b0, -1, -1);
        #2 rst = 1'b1;
        #1;
        check_eq("mrst_data", cur_data, 0);
        check_eq("mrst_valid", cur_valid, 0);
        check_eq("mrst_busy", cur_busy, 0);
        check_eq("mrst_done", cur_done, 0);
        check_eq("mrst_ovf", cur_ovf, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        exp_q.delete();
        push_seq(6, 32, oa);
        start_run();
        stream(6, 1'b0, -1, -1);
        do_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
